// File: rtl/capture_readout.sv
// capture_readout: streams a finished capture buffer out of the sample BRAM.
// Emits a 3-byte little-endian length header followed by samples 0..cnt-1
// on a valid/ready byte stream. BRAM reads run ahead of the stream into a
// small FIFO. Every read reserves a FIFO slot when it is issued, so data that
// returns from the BRAM always has room.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; busy=0
// S_HEADER | presenting length bytes cnt[7:0], cnt[15:8], cnt[23:16]
// S_READ   | streaming sample bytes from the FIFO head
// S_FINISH | one-cycle completion; busy already 0, done already 1

module capture_readout #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] sample_count,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_READ,
        S_FINISH
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [23:0]       cnt_ext;
    logic [ADDR_W:0]   cnt_m1;
    logic [1:0]        hdr_idx;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   tx_cnt;
    logic [CNT_W-1:0]  occ;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  fifo_wr;
    logic [PTR_W-1:0]  fifo_rd;
    logic [CNT_W-1:0]  fifo_cnt;
    logic [RD_LAT-1:0] pipe;

    logic hs;
    logic out_free;
    logic fifo_empty;
    logic push;
    logic pop;
    logic issue;
    logic last_hs;

    // Header byte 2 is zero-extended when the address is narrower than 24 bits.
    assign cnt_ext    = 24'(cnt);
    assign cnt_m1     = {1'b0, cnt} - {{ADDR_W{1'b0}}, 1'b1};
    assign hs         = m_valid & m_ready;
    assign out_free   = ~m_valid | m_ready;
    assign fifo_empty = (fifo_cnt == '0);
    // pipe tracks reads in flight. The oldest stage marks a returning beat.
    // Abort drops a returning beat instead of pushing it.
    assign push       = pipe[RD_LAT-1] & ~abort;

    // Decide this cycle's FIFO pop, final handshake and next BRAM read.
    always_comb begin
        pop     = 1'b0;
        last_hs = 1'b0;
        issue   = 1'b0;
        if (!abort) begin
            case (state)
                S_HEADER: begin
                    pop = hs && (hdr_idx == 2'd2) && (cnt != '0) && !fifo_empty;
                end
                S_READ: begin
                    last_hs = hs && (tx_cnt == cnt_m1);
                    pop     = out_free && !last_hs && !fifo_empty;
                end
                default: ;
            endcase
            if (state == S_HEADER || state == S_READ) begin
                issue = (rd_ptr < {1'b0, cnt}) && (occ < CNT_W'(FIFO_DEPTH));
            end
        end
    end

    // Capture returning BRAM data into the output FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[fifo_wr] <= bram_dout;
        end
    end

    // Sequencer: header, read scheduling, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            hdr_idx   <= '0;
            rd_ptr    <= '0;
            tx_cnt    <= '0;
            occ       <= '0;
            fifo_wr   <= '0;
            fifo_rd   <= '0;
            fifo_cnt  <= '0;
            pipe      <= '0;
            bram_en   <= 1'b0;
            bram_addr <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pipe     <= RD_LAT'({pipe, bram_en});
            bram_en  <= 1'b0;
            fifo_cnt <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
            occ      <= occ + CNT_W'(issue) - CNT_W'(pop);

            if (push) begin
                fifo_wr <= fifo_wr + 1'b1;
            end
            if (pop) begin
                fifo_rd <= fifo_rd + 1'b1;
                m_data  <= fifo_mem[fifo_rd];
                m_valid <= 1'b1;
            end
            if (issue) begin
                bram_en   <= 1'b1;
                bram_addr <= rd_ptr[ADDR_W-1:0];
                rd_ptr    <= rd_ptr + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        state   <= S_HEADER;
                        cnt     <= sample_count;
                        done    <= 1'b0;
                        busy    <= 1'b1;
                        hdr_idx <= 2'd0;
                        tx_cnt  <= '0;
                        m_data  <= sample_count[7:0];
                        m_valid <= 1'b1;
                        // The first read goes out alongside the first header
                        // byte so sample 0 is ready when the header ends.
                        if (sample_count != '0) begin
                            bram_en   <= 1'b1;
                            bram_addr <= '0;
                            rd_ptr    <= {{ADDR_W{1'b0}}, 1'b1};
                            occ       <= CNT_W'(1);
                        end else begin
                            rd_ptr <= '0;
                            occ    <= '0;
                        end
                    end
                end
                S_HEADER: begin
                    if (hs) begin
                        if (hdr_idx == 2'd2) begin
                            if (cnt == '0) begin
                                state   <= S_FINISH;
                                m_valid <= 1'b0;
                                busy    <= 1'b0;
                                done    <= 1'b1;
                            end else begin
                                state <= S_READ;
                                if (!pop) begin
                                    m_valid <= 1'b0;
                                end
                            end
                        end else begin
                            hdr_idx <= hdr_idx + 2'd1;
                            m_data  <= (hdr_idx == 2'd0) ? cnt_ext[15:8] : cnt_ext[23:16];
                        end
                    end
                end
                S_READ: begin
                    if (hs) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                    if (last_hs) begin
                        state   <= S_FINISH;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (out_free && !pop) begin
                        m_valid <= 1'b0;
                    end
                end
                S_FINISH: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Abort flushes everything and leaves done cleared from start.
            if (abort && state != S_IDLE) begin
                state    <= S_IDLE;
                m_valid  <= 1'b0;
                busy     <= 1'b0;
                bram_en  <= 1'b0;
                pipe     <= '0;
                occ      <= '0;
                fifo_cnt <= '0;
                fifo_wr  <= '0;
                fifo_rd  <= '0;
            end
        end
    end

endmodule
